cpu_run_ctrl: RTL

- Hardware run/step controller for the 16-bit CPU. It generates the CPU clock-enable for a bounded number of cycles, single-steps, or halts.
- It replaces the bench-only "toggle N clocks then stop" sequencing with synthesizable control.
- Sits between the board/debug controls and the CPU core's clock-enable input. It exposes a cycle counter and status.

---
 rtl/cpu_run_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller that gates the CPU core clock-enable.
// It can run for a bounded number of enabled cycles, run freely until halted,
// or single-step one cycle. It also keeps a saturating count of enabled cycles.
//
// Optional feature macro: CPU_RUN_BKPT_EN
//   When defined, a RUN stops at Pc == Bkpt_addr and sets the sticky Bkpt_hit flag.
//   When undefined, Pc and Bkpt_addr are unused and Bkpt_hit is always 0.
//
// Ports:
//   Clock        in   system clock; all state changes on the rising edge
//   Resetn       in   asynchronous active-low reset
//   Start        in   begin a bounded run or a free run (level-sampled)
//   Step         in   request one enabled CPU cycle (level-sampled)
//   Halt_req     in   stop the current run
//   Use_default  in   when Cycle_limit == 0, load DEF_LIMIT instead of free-running
//   Cycle_limit  in   number of enabled cycles to run; 0 means free-run
//   Pc           in   CPU program counter (breakpoint feature only)
//   Bkpt_addr    in   breakpoint address (breakpoint feature only)
//   Cpu_en       out  registered clock-enable to the CPU core
//   Running      out  high while in RUN
//   Done         out  one-cycle pulse when a bounded run completes
//   Cycle_count  out  enabled cycles since the last Start (saturating)
//   Bkpt_hit     out  sticky breakpoint flag
module cpu_run_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DEF_LIMIT = 30
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Step,
    input  logic             Halt_req,
    input  logic             Use_default,
    input  logic [CNT_W-1:0] Cycle_limit,
    input  logic [15:0]      Pc,
    input  logic [15:0]      Bkpt_addr,
    output logic             Cpu_en,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] Cycle_count,
    output logic             Bkpt_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEF_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             bkpt_q, bkpt_d;

    logic [CNT_W-1:0] cnt_inc_c;
    logic             bkpt_match_c;

    // Breakpoint comparator, or a constant 0 when the feature is compiled out
`ifdef CPU_RUN_BKPT_EN
    assign bkpt_match_c = (Pc == Bkpt_addr);
`else
    logic unused_bkpt_c;
    assign unused_bkpt_c = ^{Pc, Bkpt_addr};
    assign bkpt_match_c  = 1'b0;
`endif

    // Saturating increment: a free run parks at all-ones instead of wrapping
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State and registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            cnt_q     <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            bkpt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            cnt_q     <= cnt_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            done_q    <= done_d;
            bkpt_q    <= bkpt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        cnt_d    = cnt_q;
        cpu_en_d = 1'b0;
        done_d   = 1'b0;
        bkpt_d   = bkpt_q;

        unique case (state_q)
            IDLE, HALTED: begin
                // Start has priority over Step
                if (Start) begin
                    limit_d  = ((Cycle_limit == '0) && Use_default) ? DEF_LIM : Cycle_limit;
                    cnt_d    = '0;
                    bkpt_d   = 1'b0;
                    state_d  = RUN;
                    cpu_en_d = 1'b1;
                end else if (Step) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
                end
            end

            RUN: begin
                // Cpu_en is high in every RUN cycle, so each one is counted
                cnt_d    = cnt_inc_c;
                cpu_en_d = 1'b1;
                if (Halt_req || bkpt_match_c) begin
                    // A halt or breakpoint wins over a limit reached in the same cycle
                    state_d  = HALTED;
                    cpu_en_d = 1'b0;
                    bkpt_d   = bkpt_q | bkpt_match_c;
                end else if ((limit_q != '0) && (cnt_inc_c == limit_q)) begin
                    state_d  = IDLE;
                    cpu_en_d = 1'b0;
                    done_d   = 1'b1;
                end
            end

            STEP: begin
                // The single step always completes; Halt_req and breakpoints are ignored
                cnt_d   = cnt_inc_c;
                state_d = HALTED;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        running_d = (state_d == RUN);
    end

    assign Cpu_en      = cpu_en_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign Cycle_count = cnt_q;
    assign Bkpt_hit    = bkpt_q;

endmodule
